soc_ctrl_obi_regfile: RTL and testbench

// - Next-generation SoC control register file: OBI subordinate with boot-address, fetch-enable,

---
 rtl/soc_ctrl_obi_regfile_pkg.sv | 41 ++++
 rtl/soc_ctrl_obi_regfile_if.sv | 26 ++
 rtl/soc_ctrl_obi_regfile_sync.sv | 21 ++
 rtl/soc_ctrl_obi_regfile.sv | 186 ++++++++++++++++++
 tb/tb_soc_ctrl_obi_regfile.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_ctrl_obi_regfile_pkg.sv
// Register map, auto-boot encodings and helpers shared by the SoC control register file.
package soc_ctrl_regs_pkg;

  localparam logic [31:0] OFF_BOOTADDR   = 32'h00;
  localparam logic [31:0] OFF_FETCHEN    = 32'h04;
  localparam logic [31:0] OFF_CORESTATUS = 32'h08;
  localparam logic [31:0] OFF_BOOTMODE   = 32'h0C;
  localparam logic [31:0] OFF_SRAM_DLY   = 32'h10;
  localparam logic [31:0] OFF_SCRATCH    = 32'h20;

  typedef enum logic [1:0] {
    BOOTMODE_DEFAULT = 2'b00,
    BOOTMODE_AUTO    = 2'b01,
    BOOTMODE_RSVD2   = 2'b10,
    BOOTMODE_RSVD3   = 2'b11
  } bootmode_e;

  typedef enum logic [1:0] {
    AB_IDLE  = 2'b00,
    AB_COUNT = 2'b01,
    AB_DONE  = 2'b10
  } autoboot_state_e;

  // Decoded address width: fixed registers plus the scratch window, never below 5 bits.
  function automatic int int_addr_width(input int num_scratch);
    int w;
    w = $clog2(32 + 4 * num_scratch);
    return (w < 5) ? 5 : w;
  endfunction

  function automatic logic [31:0] apply_be(input logic [31:0] cur, input logic [31:0] wdata,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/soc_ctrl_obi_regfile_if.sv
// OBI request/response bundle between the peripheral crossbar and the SoC control register file.
interface soc_ctrl_obi_regfile_if #(
  parameter int IdWidth = 1
);
  logic               req;
  logic               gnt;
  logic [31:0]        addr;
  logic               we;
  logic [3:0]         be;
  logic [31:0]        wdata;
  logic [IdWidth-1:0] aid;
  logic               rvalid;
  logic [31:0]        rdata;
  logic               err;
  logic [IdWidth-1:0] rid;

  modport master (
    output req, addr, we, be, wdata, aid,
    input  gnt, rvalid, rdata, err, rid
  );

  modport slave (
    input  req, addr, we, be, wdata, aid,
    output gnt, rvalid, rdata, err, rid
  );
endinterface

// File: rtl/soc_ctrl_obi_regfile_sync.sv
// Two-flop synchroniser for asynchronous level inputs; cleared by reset.
module soc_ctrl_obi_regfile_sync #(
  parameter int Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);
  logic [Width-1:0] meta_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      q_o    <= '0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end
endmodule

// File: rtl/soc_ctrl_obi_regfile.sv
// SoC control register file: OBI subordinate for boot control, core status, SRAM delay, scratch.
//
// state    | meaning
// AB_IDLE  | waiting for synced bootmode == AUTO
// AB_COUNT | counting down towards automatic fetch enable
// AB_DONE  | fetch enable decided (auto or software); terminal until reset
module soc_ctrl_obi_regfile
  import soc_ctrl_regs_pkg::*;
#(
  parameter int          NumScratch      = 4,
  parameter int          IdWidth         = 1,
  parameter logic [31:0] BootAddrDefault = 32'h1000_0000,
  parameter int          SramDlyWidth    = 4,
  parameter int          AutoBootDelay   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  soc_ctrl_obi_regfile_if.slave   obi,
  input  logic [1:0]              bootmode_i,
  output logic [31:0]             boot_addr_o,
  output logic                    fetch_en_o,
  output logic [31:0]             core_status_o,
  output logic [SramDlyWidth-1:0] sram_dly_o
);
  localparam int IntAddrWidth = int_addr_width(NumScratch);
  localparam int NS           = (NumScratch > 0) ? NumScratch : 1;
  localparam int CntW         = (AutoBootDelay > 1) ? $clog2(AutoBootDelay) : 1;

  logic [31:0]             boot_addr_q;
  logic                    fetch_en_q;
  logic [31:0]             core_status_q;
  logic [SramDlyWidth-1:0] sram_dly_q;
  logic [31:0]             scratch_q [NS];
  logic [1:0]              bootmode_sync;

  logic                    rvalid_q;
  logic [31:0]             rdata_q;
  logic                    err_q;
  logic [IdWidth-1:0]      rid_q;

  autoboot_state_e         state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    hw_fetch_set;

  logic [31:0]             off, sidx, rd_val, wval, rdata_d;
  logic                    scr_hit, err_d, wr_ok;
  logic                    sel_boot, sel_fetch, sel_core, sel_sram;
  logic [NS-1:0]           scr_sel;

  logic unused_addr;
  assign unused_addr = ^obi.addr[31:IntAddrWidth];

  soc_ctrl_obi_regfile_sync #(.Width(2)) u_bootmode_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (bootmode_i),
    .q_o    (bootmode_sync)
  );

  // Address decode; rd_val is the selected register's current value, also the base for BE merges.
  always_comb begin
    off = '0;
    off[IntAddrWidth-1:0] = obi.addr[IntAddrWidth-1:0];
    sidx      = (off - OFF_SCRATCH) >> 2;
    scr_hit   = (NumScratch > 0) && (off >= OFF_SCRATCH) && (sidx < 32'(NumScratch));
    rd_val    = '0;
    err_d     = 1'b0;
    sel_boot  = 1'b0;
    sel_fetch = 1'b0;
    sel_core  = 1'b0;
    sel_sram  = 1'b0;
    scr_sel   = '0;
    if (obi.addr[1:0] != 2'b00) begin
      err_d = 1'b1;
    end else if (off == OFF_BOOTADDR) begin
      sel_boot = 1'b1;
      rd_val   = boot_addr_q;
    end else if (off == OFF_FETCHEN) begin
      sel_fetch = 1'b1;
      rd_val    = {31'b0, fetch_en_q};
    end else if (off == OFF_CORESTATUS) begin
      sel_core = 1'b1;
      rd_val   = core_status_q;
    end else if (off == OFF_BOOTMODE) begin
      rd_val = {30'b0, bootmode_sync};
      err_d  = obi.we;
    end else if (off == OFF_SRAM_DLY) begin
      sel_sram = 1'b1;
      rd_val   = 32'(sram_dly_q);
    end else if (scr_hit) begin
      for (int i = 0; i < NS; i++) begin
        if (sidx == 32'(i)) begin
          scr_sel[i] = 1'b1;
          rd_val     = scratch_q[i];
        end
      end
    end else begin
      err_d = 1'b1;
    end
    wval    = apply_be(rd_val, obi.wdata, obi.be);
    wr_ok   = obi.req && obi.we && !err_d;
    rdata_d = (err_d || obi.we) ? 32'b0 : rd_val;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hw_fetch_set = 1'b0;
    case (state_q)
      AB_IDLE: begin
        if (wr_ok && sel_fetch) begin
          state_d = AB_DONE;
        end else if (bootmode_sync == BOOTMODE_AUTO) begin
          state_d = AB_COUNT;
          cnt_d   = CntW'(AutoBootDelay - 1);
        end
      end
      AB_COUNT: begin
        if (wr_ok && sel_fetch) begin
          state_d = AB_DONE;
        end else if (cnt_q == '0) begin
          hw_fetch_set = 1'b1;
          state_d      = AB_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      AB_DONE: state_d = AB_DONE;
      default: state_d = AB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= AB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Software write is ordered after the sequencer set so it wins on a same-cycle collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      boot_addr_q   <= BootAddrDefault;
      fetch_en_q    <= 1'b0;
      core_status_q <= '0;
      sram_dly_q    <= '0;
      for (int i = 0; i < NS; i++) scratch_q[i] <= '0;
    end else begin
      if (hw_fetch_set)         fetch_en_q    <= 1'b1;
      if (wr_ok && sel_fetch)   fetch_en_q    <= wval[0];
      if (wr_ok && sel_boot)    boot_addr_q   <= wval;
      if (wr_ok && sel_core)    core_status_q <= wval;
      if (wr_ok && sel_sram)    sram_dly_q    <= wval[SramDlyWidth-1:0];
      for (int i = 0; i < NS; i++) begin
        if (wr_ok && scr_sel[i]) scratch_q[i] <= wval;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      rid_q    <= '0;
    end else begin
      rvalid_q <= obi.req;
      rdata_q  <= obi.req ? rdata_d : 32'b0;
      err_q    <= obi.req && err_d;
      rid_q    <= obi.aid;
    end
  end

  assign obi.gnt       = obi.req;
  assign obi.rvalid    = rvalid_q;
  assign obi.rdata     = rdata_q;
  assign obi.err       = err_q;
  assign obi.rid       = rid_q;
  assign boot_addr_o   = boot_addr_q;
  assign fetch_en_o    = fetch_en_q;
  assign core_status_o = core_status_q;
  assign sram_dly_o    = sram_dly_q;
endmodule

// File: tb/tb_soc_ctrl_obi_regfile.sv
// Bench for soc_ctrl_obi_regfile: scoreboard of expected OBI responses plus direct output checks.
module tb_soc_ctrl_obi_regfile;
  localparam int AUTO = 16;

  logic        clk_i;
  logic        rst_ni;
  logic [1:0]  bootmode_i;
  logic [31:0] boot_addr_o;
  logic        fetch_en_o;
  logic [31:0] core_status_o;
  logic [3:0]  sram_dly_o;

  soc_ctrl_obi_regfile_if #(.IdWidth(1)) obi ();

  soc_ctrl_obi_regfile #(
    .NumScratch      (4),
    .IdWidth         (1),
    .BootAddrDefault (32'h1000_0000),
    .SramDlyWidth    (4),
    .AutoBootDelay   (AUTO)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .obi           (obi),
    .bootmode_i    (bootmode_i),
    .boot_addr_o   (boot_addr_o),
    .fetch_en_o    (fetch_en_o),
    .core_status_o (core_status_o),
    .sram_dly_o    (sram_dly_o)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    logic [0:0]  rid;
    int          due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Response monitor: each expected response must appear exactly on its due cycle.
  always @(posedge clk_i) begin
    cyc = cyc + 1;
    #1;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      mon_e = sbq.pop_front();
      checks++;
      if (obi.rvalid !== 1'b1 || obi.rdata !== mon_e.rdata || obi.err !== mon_e.err ||
          obi.rid !== mon_e.rid) begin
        errors++;
        $display("FAIL resp_%s: got rvalid=%b rdata=%h err=%b rid=%b, required rvalid=1 rdata=%h err=%b rid=%b",
                 mon_e.name, obi.rvalid, obi.rdata, obi.err, obi.rid, mon_e.rdata, mon_e.err, mon_e.rid);
      end
    end else if (obi.rvalid === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL unexpected_rvalid: got rvalid=1 at cycle %0d, required rvalid=0", cyc);
    end
  end

  task automatic xfer(input string nm, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    exp_t       e;
    logic [0:0] id;
    id        = 1'($urandom_range(0, 1));
    obi.req   = 1'b1;
    obi.we    = we;
    obi.addr  = addr;
    obi.be    = be;
    obi.wdata = wdata;
    obi.aid   = id;
    e.name    = nm;
    e.rdata   = exp_rdata;
    e.err     = exp_err;
    e.rid     = id;
    e.due     = cyc + 1;
    sbq.push_back(e);
    @(negedge clk_i);
  endtask

  task automatic idle_bus();
    obi.req   = 1'b0;
    obi.we    = 1'b0;
    obi.addr  = '0;
    obi.be    = '0;
    obi.wdata = '0;
    obi.aid   = '0;
  endtask

  task automatic drain();
    idle_bus();
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d responses outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    checks++;
    if (boot_addr_o !== 32'h1000_0000) begin
      errors++; $display("FAIL rst_boot_addr: got %h, required 10000000", boot_addr_o);
    end
    checks++;
    if (fetch_en_o !== 1'b0) begin
      errors++; $display("FAIL rst_fetch_en: got %b, required 0", fetch_en_o);
    end
    checks++;
    if (core_status_o !== 32'h0) begin
      errors++; $display("FAIL rst_core_status: got %h, required 0", core_status_o);
    end
    checks++;
    if (sram_dly_o !== 4'h0 || obi.rvalid !== 1'b0) begin
      errors++; $display("FAIL rst_sram_rvalid: got sram=%h rvalid=%b, required 0 0", sram_dly_o, obi.rvalid);
    end
    xfer("rd_bootaddr", 1'b0, 32'h00, 4'hF, '0, 32'h1000_0000, 1'b0);
    xfer("rd_fetchen",  1'b0, 32'h04, 4'hF, '0, 32'h0, 1'b0);
    xfer("rd_corestat", 1'b0, 32'h08, 4'hF, '0, 32'h0, 1'b0);
    xfer("rd_bootmode", 1'b0, 32'h0C, 4'hF, '0, 32'h0, 1'b0);
    xfer("rd_sramdly",  1'b0, 32'h10, 4'hF, '0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) xfer("rd_scratch", 1'b0, 32'h20 + 32'(4 * i), 4'hF, '0, 32'h0, 1'b0);
    drain();
  endtask

  task automatic test_byte_enable();
    xfer("wr_scratch1_be", 1'b1, 32'h24, 4'b0101, 32'hDEAD_BEEF, 32'h0, 1'b0);
    xfer("rd_scratch1_be", 1'b0, 32'h24, 4'hF, '0, 32'h00AD_00EF, 1'b0);
    xfer("rd_scratch0",    1'b0, 32'h20, 4'hF, '0, 32'h0, 1'b0);
    xfer("wr_bootaddr_b3", 1'b1, 32'h00, 4'b1000, 32'hAB12_3456, 32'h0, 1'b0);
    xfer("wr_corestat",    1'b1, 32'h08, 4'hF, 32'h1234_5678, 32'h0, 1'b0);
    xfer("rd_bootaddr_b3", 1'b0, 32'h00, 4'hF, '0, 32'hAB00_0000, 1'b0);
    drain();
    checks++;
    if (boot_addr_o !== 32'hAB00_0000) begin
      errors++; $display("FAIL boot_addr_o_be: got %h, required ab000000", boot_addr_o);
    end
    checks++;
    if (core_status_o !== 32'h1234_5678) begin
      errors++; $display("FAIL core_status_o: got %h, required 12345678", core_status_o);
    end
  endtask

  task automatic test_errors();
    xfer("rd_misaligned", 1'b0, 32'h0E, 4'hF, '0, 32'h0, 1'b1);
    xfer("rd_unmapped14", 1'b0, 32'h14, 4'hF, '0, 32'h0, 1'b1);
    xfer("wr_bootmode",   1'b1, 32'h0C, 4'hF, 32'h3, 32'h0, 1'b1);
    xfer("wr_misal_scr",  1'b1, 32'h26, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
    xfer("rd_unmapped30", 1'b0, 32'h30, 4'hF, '0, 32'h0, 1'b1);
    xfer("rd_bootmode_ok", 1'b0, 32'h0C, 4'hF, '0, 32'h0, 1'b0);
    xfer("rd_scratch1_kept", 1'b0, 32'h24, 4'hF, '0, 32'h00AD_00EF, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    xfer("wr_sramdly", 1'b1, 32'h10, 4'hF, 32'h0000_00FF, 32'h0, 1'b0);
    xfer("rd_sramdly_b2b", 1'b0, 32'h10, 4'hF, '0, 32'h0000_000F, 1'b0);
    xfer("wr_scratch3", 1'b1, 32'h2C, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0);
    xfer("rd_scratch3_b2b", 1'b0, 32'h2C, 4'hF, '0, 32'hCAFE_F00D, 1'b0);
    drain();
    checks++;
    if (sram_dly_o !== 4'hF) begin
      errors++; $display("FAIL sram_dly_o: got %h, required f", sram_dly_o);
    end
  endtask

  task automatic test_autoboot();
    int n;
    bit seen;
    drain();
    bootmode_i = 2'b01;
    rst_ni     = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    // Latency is counted from the first clock edge after release.
    @(posedge clk_i);
    n    = 0;
    seen = 0;
    while (!seen && n < AUTO + 10) begin
      @(posedge clk_i);
      #1;
      n++;
      if (fetch_en_o === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || n != AUTO + 2) begin
      errors++; $display("FAIL autoboot_latency: got seen=%0d after %0d cycles, required %0d", seen, n, AUTO + 2);
    end
    @(negedge clk_i);
    bootmode_i = 2'b00;
    xfer("rd_bootmode_auto", 1'b0, 32'h0C, 4'hF, '0, 32'h1, 1'b0);
    xfer("rd_fetchen_auto",  1'b0, 32'h04, 4'hF, '0, 32'h1, 1'b0);
    xfer("rd_bootaddr_rst",  1'b0, 32'h00, 4'hF, '0, 32'h1000_0000, 1'b0);
    drain();
  endtask

  task automatic test_sw_override();
    drain();
    bootmode_i = 2'b01;
    rst_ni     = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (fetch_en_o !== 1'b0) begin
      errors++; $display("FAIL midcount_reset_fetch: got %b, required 0", fetch_en_o);
    end
    rst_ni = 1'b1;
    repeat (6) @(negedge clk_i);
    xfer("wr_fetchen_zero", 1'b1, 32'h04, 4'hF, 32'h0, 32'h0, 1'b0);
    idle_bus();
    repeat (AUTO + 8) @(negedge clk_i);
    checks++;
    if (fetch_en_o !== 1'b0) begin
      errors++; $display("FAIL sw_override_hold: got %b, required 0", fetch_en_o);
    end
    xfer("rd_fetchen_override", 1'b0, 32'h04, 4'hF, '0, 32'h0, 1'b0);
    xfer("wr_fetchen_ones",     1'b1, 32'h04, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0);
    xfer("rd_fetchen_ones",     1'b0, 32'h04, 4'hF, '0, 32'h1, 1'b0);
    drain();
    checks++;
    if (fetch_en_o !== 1'b1) begin
      errors++; $display("FAIL sw_fetch_set: got %b, required 1", fetch_en_o);
    end
  endtask

  initial begin
    rst_ni     = 1'b0;
    bootmode_i = 2'b00;
    idle_bus();
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    test_reset();
    test_byte_enable();
    test_errors();
    test_back_to_back();
    test_autoboot();
    test_sw_override();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
